// File: rtl/frame_cmd_sequencer_pkg.sv
// Shared definitions for the frame command sequencer: command word layout,
// info codes, FSM state encoding and raster defaults.
package frame_cmd_sequencer_pkg;

    localparam logic [3:0] INFO_WRITE          = 4'b0001;
    localparam logic [3:0] INFO_FLUSH          = 4'b1111;
    localparam logic [9:0] VBLANK_LINE_DEFAULT = 10'd480;

    // Field order matches the command word from bit 31 down to bit 0.
    typedef struct packed {
        logic [5:0]  sub_comp;
        logic [4:0]  child;
        logic [3:0]  info;
        logic [2:0]  cmd_type;
        logic        pp_selc;
        logic [12:0] msg;
    } cmd_word_t;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'b00,
        ST_WAIT_VBLANK = 2'b01,
        ST_FLUSH       = 2'b10
    } seq_state_e;

    function automatic cmd_word_t retarget_word(input cmd_word_t w, input logic back);
        cmd_word_t r;
        r         = w;
        r.pp_selc = back;
        return r;
    endfunction

    function automatic cmd_word_t flush_word(input logic back);
        cmd_word_t r;
        r         = '0;
        r.info    = INFO_FLUSH;
        r.pp_selc = back;
        return r;
    endfunction

endpackage

// File: rtl/frame_cmd_sequencer_cmd_fifo.sv
// Single-clock command FIFO with registered occupancy and full/empty flags.
// The head word is presented combinationally from the read pointer.
module cmd_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             full_q;
    logic             empty_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push_i && !full_q;
    assign do_pop_s  = pop_i && !empty_q;
    assign head_o    = mem_q[rd_ptr_q];
    assign full_o    = full_q;
    assign empty_o   = empty_q;

    // Occupancy next-state; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers, count and flags; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == (AW+1)'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // Storage array; contents need no reset since the flags gate every read.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/frame_cmd_sequencer.sv
// Queues software display commands and broadcasts them to the sub-components,
// retargeting each at the back buffer and flipping buffers on vertical blank.
module frame_cmd_sequencer
    import frame_cmd_sequencer_pkg::*;
#(
    parameter int         FIFO_DEPTH  = 16,
    parameter logic [9:0] VBLANK_LINE = VBLANK_LINE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [31:0] cmd_data,
    output logic        cmd_ready,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    output logic [31:0] writedata,
    output logic        front_sel,
    output logic [15:0] frame_count
);

    seq_state_e  state_q;
    seq_state_e  state_d;
    logic [31:0] wd_q;
    logic [31:0] wd_d;
    logic        front_q;
    logic        front_d;
    logic [15:0] fc_q;
    logic [15:0] fc_d;
    logic        vb_level_q;
    logic        alive_q;

    cmd_word_t   fifo_head_s;
    logic        fifo_full_s;
    logic        fifo_empty_s;
    logic        push_s;
    logic        pop_s;
    logic        vb_level_s;
    logic        vblank_rise_s;
    logic        unused_hcount_s;

    assign unused_hcount_s = ^hcount;

    assign cmd_ready     = alive_q && !fifo_full_s;
    assign push_s        = cmd_valid && cmd_ready;
    assign pop_s         = (state_q == ST_IDLE) && !fifo_empty_s;
    assign vb_level_s    = (vcount >= VBLANK_LINE);
    assign vblank_rise_s = vb_level_s && !vb_level_q;

    assign writedata   = wd_q;
    assign front_sel   = front_q;
    assign frame_count = fc_q;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_cmd_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push_s),
        .push_data_i (cmd_data),
        .pop_i       (pop_s),
        .head_o      (fifo_head_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s)
    );

    // Sequencer next-state: a commit parks the FSM until the next vblank edge.
    always_comb begin
        state_d = state_q;
        wd_d    = 32'h0000_0000;
        front_d = front_q;
        fc_d    = fc_q;
        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    if (fifo_head_s.info == INFO_FLUSH) begin
                        state_d = ST_WAIT_VBLANK;
                    end else begin
                        wd_d = retarget_word(fifo_head_s, !front_q);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_VBLANK: begin
                if (vblank_rise_s) begin
                    state_d = ST_FLUSH;
                    wd_d    = flush_word(!front_q);
                end else begin
                    state_d = ST_WAIT_VBLANK;
                end
            end
            ST_FLUSH: begin
                state_d = ST_IDLE;
                front_d = !front_q;
                fc_d    = fc_q + 16'd1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered FSM state, broadcast word, buffer select and flip counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wd_q       <= 32'h0000_0000;
            front_q    <= 1'b0;
            fc_q       <= 16'h0000;
            vb_level_q <= 1'b0;
            alive_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wd_q       <= wd_d;
            front_q    <= front_d;
            fc_q       <= fc_d;
            vb_level_q <= vb_level_s;
            alive_q    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_frame_cmd_sequencer.sv
// Directed and randomized bench for frame_cmd_sequencer against a queue-based
// reference model of the command stream and buffer flips.
module tb_frame_cmd_sequencer;
    import frame_cmd_sequencer_pkg::*;

    localparam int         DEPTH = 16;
    localparam logic [9:0] VBL   = 10'd480;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [31:0] cmd_data;
    logic        cmd_ready;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [31:0] writedata;
    logic        front_sel;
    logic [15:0] frame_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] q[$];
    bit          m_alive, m_vb_prev, m_wait, m_flush, m_front, m_accepted;
    logic [15:0] m_fc;
    logic [31:0] m_wd;
    int          idx;

    always #5 clk = ~clk;

    frame_cmd_sequencer #(
        .FIFO_DEPTH  (DEPTH),
        .VBLANK_LINE (VBL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_data    (cmd_data),
        .cmd_ready   (cmd_ready),
        .hcount      (hcount),
        .vcount      (vcount),
        .writedata   (writedata),
        .front_sel   (front_sel),
        .frame_count (frame_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_alive = 1'b0; m_vb_prev = 1'b0; m_wait = 1'b0; m_flush = 1'b0;
        m_front = 1'b0; m_accepted = 1'b0;
        m_fc = 16'h0; m_wd = 32'h0;
    endtask

    // One clock of the reference behaviour, using the inputs seen at the edge.
    task automatic model_step();
        logic [31:0] w;
        logic [31:0] nwd;
        bit level, rise;
        level      = (vcount >= VBL);
        rise       = level && !m_vb_prev;
        m_accepted = cmd_valid && m_alive && (q.size() < DEPTH);
        nwd        = 32'h0;
        if (m_flush) begin
            m_front = !m_front;
            m_fc    = m_fc + 16'd1;
            m_flush = 1'b0;
        end else if (m_wait) begin
            if (rise) begin
                m_wait  = 1'b0;
                m_flush = 1'b1;
                nwd     = m_front ? 32'h001E0000 : 32'h001E2000;
            end
        end else if (q.size() != 0) begin
            w = q.pop_front();
            if (w[20:17] == 4'hF) begin
                m_wait = 1'b1;
            end else begin
                nwd     = w;
                nwd[13] = !m_front;
            end
        end
        if (m_accepted) q.push_back(cmd_data);
        m_vb_prev = level;
        m_alive   = 1'b1;
        m_wd      = nwd;
    endtask

    task automatic compare_model();
        check("writedata", writedata, m_wd);
        check("front_sel", {31'h0, front_sel}, {31'h0, m_front});
        check("frame_count", {16'h0, frame_count}, {16'h0, m_fc});
        check("cmd_ready", {31'h0, cmd_ready}, {31'h0, (m_alive && (q.size() < DEPTH))});
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic push(input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_data  = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; cmd_valid = 1'b0; cmd_data = 32'h0; hcount = 10'd0; vcount = 10'd0;
        model_reset();
        #1;
        check("rst_writedata", writedata, 32'h0);
        check("rst_front", {31'h0, front_sel}, 32'h0);
        check("rst_count", {16'h0, frame_count}, 32'h0);
        check("rst_ready", {31'h0, cmd_ready}, 32'h0);
        tick(); tick();
        reset = 1'b1;
        tick();
        check("ready_after_release", {31'h0, cmd_ready}, 32'h1);

        // Single write: two-cycle latency, one-cycle pulse, back buffer bit set.
        push(32'h3C028064);
        tick();
        check("single_write", writedata, 32'h3C02A064);
        tick();
        check("single_write_idle", writedata, 32'h0);

        // Three writes then a commit, flipped on the vblank edge.
        push(32'h04020011);
        check("w1_early", writedata, 32'h0);
        push(32'h08022022);
        check("w1_out", writedata, 32'h04022011);
        push(32'h0C020033);
        push(32'h001E0000);
        repeat (3) tick();
        vcount = VBL;
        tick();
        check("flip1_flush", writedata, 32'h001E2000);
        tick();
        check("flip1_front", {31'h0, front_sel}, 32'h1);
        check("flip1_count", {16'h0, frame_count}, 32'h1);
        vcount = 10'd0;
        tick();

        // Reset while waiting for vblank with five words queued.
        push(32'h001E0000);
        for (int i = 0; i < 5; i++) push(32'h00020100 + 32'(i));
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        check("midrst_wd", writedata, 32'h0);
        check("midrst_front", {31'h0, front_sel}, 32'h0);
        check("midrst_count", {16'h0, frame_count}, 32'h0);
        tick(); tick();
        reset = 1'b1;
        tick();
        vcount = VBL;
        tick(); tick(); tick();
        check("midrst_no_flush_wd", writedata, 32'h0);
        check("midrst_no_flush_cnt", {16'h0, frame_count}, 32'h0);
        vcount = 10'd0;
        tick();

        // A write queued behind a commit targets the new back buffer.
        push(32'h001E0000);
        push(32'h3C028064);
        repeat (3) tick();
        check("held_write", writedata, 32'h0);
        vcount = VBL;
        tick();
        check("flip2_flush", writedata, 32'h001E2000);
        tick();
        check("flip2_front", {31'h0, front_sel}, 32'h1);
        tick();
        check("held_write_out", writedata, 32'h3C028064);
        vcount = 10'd0;
        tick();

        // Fill the FIFO while parked; nothing may be lost.
        push(32'h001E0000);
        idx = 0;
        for (int c = 0; c < DEPTH + 4; c++) begin
            cmd_valid = 1'b1;
            cmd_data  = 32'h00020000 + 32'(idx);
            tick();
            if (m_accepted) idx++;
        end
        cmd_valid = 1'b0;
        check("full_accepted", 32'(idx), 32'(DEPTH));
        check("full_ready", {31'h0, cmd_ready}, 32'h0);
        vcount = VBL;
        tick();
        check("flip3_flush", writedata, 32'h001E0000);
        tick();
        tick();
        check("drain_first", writedata, 32'h00022000);
        repeat (DEPTH + 1) tick();
        vcount = 10'd0;
        tick();

        // Commit popped on the same edge as the vblank rise waits a frame.
        push(32'h001E0000);
        vcount = VBL;
        tick(); tick(); tick();
        check("sameedge_wd", writedata, 32'h0);
        check("sameedge_cnt", {16'h0, frame_count}, 32'h2);
        vcount = 10'd0;
        tick();
        vcount = VBL;
        tick();
        check("nextframe_flush", writedata, 32'h001E2000);
        tick();
        check("nextframe_cnt", {16'h0, frame_count}, 32'h3);
        vcount = 10'd0;
        tick();

        // Randomized traffic with periodic vblank.
        for (int c = 0; c < 600; c++) begin
            int r;
            r         = int'($urandom_range(0, 9));
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_data  = $urandom();
            if (r == 0) cmd_data[20:17] = INFO_FLUSH;
            else if (cmd_data[20:17] == INFO_FLUSH) cmd_data[20:17] = INFO_WRITE;
            vcount = ((c % 30) >= 25) ? 10'(480 + (c % 30)) : 10'($urandom_range(0, 479));
            hcount = 10'($urandom_range(0, 799));
            tick();
        end
        cmd_valid = 1'b0;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
